if_fetch_stage: RTL and testbench

IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

---
 rtl/if_fetch_stage.sv | 122 ++++++++++++
 tb/tb_if_fetch_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: pairs pre-IF entries with in-order instruction
// responses, buffers a word under decode back-pressure and drops flushed responses.
module if_fetch_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        pfs_to_fs_valid,
  input  logic        pfs_req_ok,
  input  logic [31:0] pfs_pc,
  input  logic        pfs_ex,
  input  logic [4:0]  pfs_exccode,
  output logic        fs_allowin,
  output logic        fs_valid,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        flush,
  input  logic        ds_allowin,
  output logic        fs_to_ds_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst,
  output logic        fs_ex,
  output logic [4:0]  fs_exccode
);

  logic        buf_valid;
  logic [31:0] inst_buf;
  logic [1:0]  discard_cnt;
  logic [1:0]  discard_nxt;
  logic [2:0]  discard_sum;

  logic data_hit;
  logic data_drop;
  logic ready_go;
  logic accept;
  logic leave;
  logic capture;
  logic pending;

  assign data_hit  = inst_data_ok & (discard_cnt == 2'd0);
  assign data_drop = inst_data_ok & (discard_cnt != 2'd0);

  assign ready_go = fs_ex | buf_valid | data_hit;

  assign fs_to_ds_valid = fs_valid & ready_go & ~flush;

  assign fs_allowin = (~fs_valid | (ready_go & ds_allowin))
                    & (discard_cnt != 2'd3);

  assign accept = pfs_to_fs_valid & fs_allowin & ~flush;
  assign leave  = fs_to_ds_valid & ds_allowin;

  assign capture = data_hit & fs_valid & ~fs_ex & ~buf_valid;

  // Held entry whose own response is still in flight.
  assign pending = fs_valid & ~fs_ex & ~buf_valid & ~data_hit;

  always_comb begin
    if (fs_ex)
      fs_inst = 32'd0;
    else if (buf_valid)
      fs_inst = inst_buf;
    else
      fs_inst = inst_rdata;
  end

  always_comb begin
    discard_sum = {1'b0, discard_cnt}
                + {2'b00, flush & pending}
                + {2'b00, flush & pfs_req_ok}
                - {2'b00, data_drop};
    if (discard_sum > 3'd3)
      discard_nxt = 2'd3;
    else
      discard_nxt = discard_sum[1:0];
  end

  always_ff @(posedge clk) begin
    if (reset)
      discard_cnt <= 2'd0;
    else
      discard_cnt <= discard_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset)
      fs_valid <= 1'b0;
    else if (flush)
      fs_valid <= 1'b0;
    else if (accept)
      fs_valid <= 1'b1;
    else if (leave)
      fs_valid <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fs_pc      <= 32'd0;
      fs_ex      <= 1'b0;
      fs_exccode <= 5'd0;
    end else if (accept) begin
      fs_pc      <= pfs_pc;
      fs_ex      <= pfs_ex;
      fs_exccode <= pfs_exccode;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      buf_valid <= 1'b0;
    else if (flush | leave)
      buf_valid <= 1'b0;
    else if (capture)
      buf_valid <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      inst_buf <= 32'd0;
    else if (capture & ~ds_allowin)
      inst_buf <= inst_rdata;
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: per-cycle vector table plus
// hand-written reset sequences.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        pfs_to_fs_valid;
  logic        pfs_req_ok;
  logic [31:0] pfs_pc;
  logic        pfs_ex;
  logic [4:0]  pfs_exccode;
  logic        fs_allowin;
  logic        fs_valid;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        flush;
  logic        ds_allowin;
  logic        fs_to_ds_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;
  logic        fs_ex;
  logic [4:0]  fs_exccode;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  if_fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .pfs_to_fs_valid(pfs_to_fs_valid),
    .pfs_req_ok     (pfs_req_ok),
    .pfs_pc         (pfs_pc),
    .pfs_ex         (pfs_ex),
    .pfs_exccode    (pfs_exccode),
    .fs_allowin     (fs_allowin),
    .fs_valid       (fs_valid),
    .inst_data_ok   (inst_data_ok),
    .inst_rdata     (inst_rdata),
    .flush          (flush),
    .ds_allowin     (ds_allowin),
    .fs_to_ds_valid (fs_to_ds_valid),
    .fs_pc          (fs_pc),
    .fs_inst        (fs_inst),
    .fs_ex          (fs_ex),
    .fs_exccode     (fs_exccode)
  );

  typedef struct {
    logic        v;
    logic        rq;
    logic [31:0] pc;
    logic        ex;
    logic [4:0]  ec;
    logic        dok;
    logic [31:0] rd;
    logic        fl;
    logic        dsa;
    logic        e_tv;
    logic        e_ai;
    logic        e_fv;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_ex;
    logic [4:0]  e_ec;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic v, input logic rq, input logic [31:0] pc,
    input logic ex, input logic [4:0] ec,
    input logic dok, input logic [31:0] rd,
    input logic fl, input logic dsa,
    input logic e_tv, input logic e_ai, input logic e_fv,
    input logic [31:0] e_pc, input logic [31:0] e_inst,
    input logic e_ex, input logic [4:0] e_ec);
    vec_t r;
    r.v = v; r.rq = rq; r.pc = pc; r.ex = ex; r.ec = ec;
    r.dok = dok; r.rd = rd; r.fl = fl; r.dsa = dsa;
    r.e_tv = e_tv; r.e_ai = e_ai; r.e_fv = e_fv;
    r.e_pc = e_pc; r.e_inst = e_inst; r.e_ex = e_ex; r.e_ec = e_ec;
    return r;
  endfunction

  task automatic drive(input vec_t r);
    pfs_to_fs_valid = r.v;
    pfs_req_ok      = r.rq;
    pfs_pc          = r.pc;
    pfs_ex          = r.ex;
    pfs_exccode     = r.ec;
    inst_data_ok    = r.dok;
    inst_rdata      = r.rd;
    flush           = r.fl;
    ds_allowin      = r.dsa;
  endtask

  // Payload fields are only meaningful while an entry is offered.
  task automatic check(input string name, input vec_t r);
    logic [72:0] got;
    logic [72:0] exp;
    got = {fs_to_ds_valid, fs_allowin, fs_valid,
           fs_pc, fs_inst, fs_ex, fs_exccode};
    exp = {r.e_tv, r.e_ai, r.e_fv, r.e_pc, r.e_inst, r.e_ex, r.e_ec};
    if (!r.e_tv) begin
      got[69:0] = '0;
      exp[69:0] = '0;
    end
    total_cnt++;
    if (got === exp)
      pass_cnt++;
    else
      $display("FAIL %s: got tv/ai/fv/pc/inst/ex/ec=%h required %h",
               name, got, exp);
  endtask

  task automatic step(input string name, input vec_t r);
    @(posedge clk);
    #1;
    drive(r);
    @(negedge clk);
    check(name, r);
  endtask

  vec_t idle;

  initial begin
    idle = mk(0,0,32'h0,0,5'h0,0,32'h0,0,1, 0,1,0,32'h0,32'h0,0,5'h0);
    drive(idle);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (fs_valid === 1'b0 && fs_to_ds_valid === 1'b0 &&
        fs_allowin === 1'b1 && fs_pc === 32'h0 &&
        fs_ex === 1'b0 && fs_exccode === 5'h0)
      pass_cnt++;
    else
      $display("FAIL reset_state: got fv=%b tv=%b ai=%b pc=%h ex=%b ec=%h required 0 0 1 0 0 0",
               fs_valid, fs_to_ds_valid, fs_allowin, fs_pc, fs_ex, fs_exccode);

    // basic fetch
    vecs.push_back(mk(1,1,32'hbfc00000,0,0, 0,32'h0,        0,1, 0,1,0,32'h0,32'h0,0,0));
    vecs.push_back(mk(0,0,32'h0,0,0,        1,32'h3c1a0001, 0,1, 1,1,1,32'hbfc00000,32'h3c1a0001,0,0));
    // decode stall, buffered word, back-to-back release
    vecs.push_back(mk(1,1,32'hbfc00004,0,0, 0,32'h0,        0,0, 0,1,0,32'h0,32'h0,0,0));
    vecs.push_back(mk(0,0,32'h0,0,0,        1,32'h11111111, 0,0, 1,0,1,32'hbfc00004,32'h11111111,0,0));
    vecs.push_back(mk(1,0,32'hbfc00008,0,0, 0,32'h22222222, 0,0, 1,0,1,32'hbfc00004,32'h11111111,0,0));
    vecs.push_back(mk(1,0,32'hbfc00008,0,0, 0,32'h22222222, 0,0, 1,0,1,32'hbfc00004,32'h11111111,0,0));
    vecs.push_back(mk(1,1,32'hbfc00008,0,0, 0,32'h22222222, 0,1, 1,1,1,32'hbfc00004,32'h11111111,0,0));
    // flush of a waiting entry
    vecs.push_back(mk(0,0,32'h0,0,0,        0,32'h0,        1,1, 0,0,1,32'h0,32'h0,0,0));
    vecs.push_back(mk(1,1,32'hbfc0000c,0,0, 1,32'hdeadbeef, 0,1, 0,1,0,32'h0,32'h0,0,0));
    vecs.push_back(mk(0,0,32'h0,0,0,        1,32'h33333333, 0,1, 1,1,1,32'hbfc0000c,32'h33333333,0,0));
    // flush with pfs_req_ok and one pending response
    vecs.push_back(mk(1,1,32'hbfc00010,0,0, 0,32'h0,        0,1, 0,1,0,32'h0,32'h0,0,0));
    vecs.push_back(mk(1,1,32'hbfc00014,0,0, 0,32'h0,        1,1, 0,0,1,32'h0,32'h0,0,0));
    vecs.push_back(mk(0,0,32'h0,0,0,        1,32'haaaa0001, 0,1, 0,1,0,32'h0,32'h0,0,0));
    vecs.push_back(mk(1,1,32'hbfc00018,0,0, 1,32'haaaa0002, 0,1, 0,1,0,32'h0,32'h0,0,0));
    vecs.push_back(mk(0,0,32'h0,0,0,        1,32'h44444444, 0,1, 1,1,1,32'hbfc00018,32'h44444444,0,0));
    // exception entry
    vecs.push_back(mk(1,0,32'hbfc00002,1,5'h04, 0,32'h0,    0,1, 0,1,0,32'h0,32'h0,0,0));
    vecs.push_back(mk(0,0,32'h0,0,0,        0,32'h99999999, 0,1, 1,1,1,32'hbfc00002,32'h0,1,5'h04));
    // continuous stream
    vecs.push_back(mk(1,1,32'hbfc00020,0,0, 0,32'h0,        0,1, 0,1,0,32'h0,32'h0,0,0));
    vecs.push_back(mk(1,1,32'hbfc00024,0,0, 1,32'h50000020, 0,1, 1,1,1,32'hbfc00020,32'h50000020,0,0));
    vecs.push_back(mk(1,1,32'hbfc00028,0,0, 1,32'h50000024, 0,1, 1,1,1,32'hbfc00024,32'h50000024,0,0));
    vecs.push_back(mk(1,1,32'hbfc0002c,0,0, 1,32'h50000028, 0,1, 1,1,1,32'hbfc00028,32'h50000028,0,0));
    vecs.push_back(mk(0,0,32'h0,0,0,        1,32'h5000002c, 0,1, 1,1,1,32'hbfc0002c,32'h5000002c,0,0));
    vecs.push_back(idle);
    // discard counter saturation blocks allowin
    vecs.push_back(mk(1,1,32'hbfc00030,0,0, 0,32'h0,        0,1, 0,1,0,32'h0,32'h0,0,0));
    vecs.push_back(mk(1,1,32'hbfc00034,0,0, 0,32'h0,        1,1, 0,0,1,32'h0,32'h0,0,0));
    vecs.push_back(mk(1,1,32'hbfc00038,0,0, 0,32'h0,        1,1, 0,1,0,32'h0,32'h0,0,0));
    vecs.push_back(mk(1,0,32'hbfc0003c,0,0, 0,32'h0,        0,1, 0,0,0,32'h0,32'h0,0,0));
    vecs.push_back(mk(0,0,32'h0,0,0,        1,32'hdead0001, 0,1, 0,0,0,32'h0,32'h0,0,0));
    vecs.push_back(mk(0,0,32'h0,0,0,        1,32'hdead0002, 0,1, 0,1,0,32'h0,32'h0,0,0));
    vecs.push_back(mk(0,0,32'h0,0,0,        1,32'hdead0003, 0,1, 0,1,0,32'h0,32'h0,0,0));
    vecs.push_back(mk(1,1,32'hbfc00040,0,0, 0,32'h0,        0,1, 0,1,0,32'h0,32'h0,0,0));
    vecs.push_back(mk(0,0,32'h0,0,0,        1,32'h60000040, 0,1, 1,1,1,32'hbfc00040,32'h60000040,0,0));
    vecs.push_back(idle);

    for (int i = 0; i < vecs.size(); i++)
      step($sformatf("vec%0d", i), vecs[i]);

    // reset overrides flush and clears a nonzero discard count
    step("pre_rst_a", mk(1,1,32'hbfc00050,0,0, 0,32'h0, 1,1, 0,1,0,32'h0,32'h0,0,0));
    step("pre_rst_b", mk(1,0,32'h12345678,1,5'h1f, 0,32'h0, 0,1, 0,1,0,32'h0,32'h0,0,0));
    @(posedge clk);
    #1;
    drive(mk(1,1,32'hbfc0005c,0,0, 0,32'h0, 1,0, 0,0,0,32'h0,32'h0,0,0));
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(idle);
    @(negedge clk);
    total_cnt++;
    if (fs_valid === 1'b0 && fs_to_ds_valid === 1'b0 &&
        fs_allowin === 1'b1 && fs_pc === 32'h0 && fs_exccode === 5'h0)
      pass_cnt++;
    else
      $display("FAIL reset_override: got fv=%b tv=%b ai=%b pc=%h ec=%h required 0 0 1 0 0",
               fs_valid, fs_to_ds_valid, fs_allowin, fs_pc, fs_exccode);
    step("post_rst_acc", mk(1,1,32'hbfc00054,0,0, 0,32'h0, 0,1, 0,1,0,32'h0,32'h0,0,0));
    step("post_rst_data", mk(0,0,32'h0,0,0, 1,32'h77777777, 0,1, 1,1,1,32'hbfc00054,32'h77777777,0,0));
    step("post_rst_idle", idle);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
